iact_router_feeder: RTL and testbench

- Per-router input-activation feeder sitting directly upstream of the PE-cluster control block.
- Accepts a word stream from the GLB-side iact router and buffers it in a small FIFO.
- Presents each word to the cluster with an enable and a set index (one lane of `iact_enables` / `iact_data_set`).
- Advances through the configured sets on each ready handshake, then signals completion.
- One instance per router; `HWC_IACT_ROUTER_CLUSTER_NUM` instances feed one cluster.

---
 rtl/iact_router_feeder_pkg.sv | 15 +
 rtl/iact_feeder_fifo.sv | 47 ++++
 rtl/iact_router_feeder.sv | 127 ++++++++++++
 tb/tb_iact_router_feeder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/iact_router_feeder_pkg.sv
// Shared configuration constants and FSM state type for the iact router feeder.
// Mirrors the hw_config values so every feeder in a cluster agrees on set sizing.
package iact_router_feeder_pkg;

    localparam int HWC_PE_CLUSTER_IACT_ROUT_CONFIG_SET_SIZE       = 4;
    localparam int HWC_PE_CLUSTER_IACT_ROUT_CONFIG_SET_SIZE_WIDTH = 2;
    localparam int HWC_IACT_FEEDER_FIFO_DEPTH                     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/iact_feeder_fifo.sv
// Small synchronous skid FIFO between the iact router and the cluster handshake.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module iact_feeder_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage is not reset; empty gating keeps stale entries from being observed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/iact_router_feeder.sv
// Per-router iact feeder: buffers router words and issues them to the PE cluster
// set by set, pulsing done on the final transfer of a pass.
module iact_router_feeder
    import iact_router_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = HWC_IACT_FEEDER_FIFO_DEPTH,
    parameter int SETS       = HWC_PE_CLUSTER_IACT_ROUT_CONFIG_SET_SIZE,
    parameter int SET_WIDTH  = HWC_PE_CLUSTER_IACT_ROUT_CONFIG_SET_SIZE_WIDTH,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SET_WIDTH:0]    cfg_sets,
    input  logic [LEN_WIDTH-1:0]  cfg_words,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  iact_enable,
    output logic [DATA_WIDTH-1:0] iact_data,
    output logic [SET_WIDTH-1:0]  iact_data_set,
    input  logic                  iact_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int PUSH_W = LEN_WIDTH + SET_WIDTH + 1;

    feeder_state_e         state;
    feeder_state_e         state_next;
    logic [SET_WIDTH:0]    sets_q;
    logic [LEN_WIDTH-1:0]  words_q;
    logic [LEN_WIDTH-1:0]  word_cnt;
    logic [SET_WIDTH:0]    set_cnt;
    logic [PUSH_W-1:0]     push_cnt;
    logic [PUSH_W-1:0]     total;
    logic                  zero_done;
    logic                  push;
    logic                  fire;
    logic                  last_fire;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  cfg_zero;
    logic [SET_WIDTH:0]    sets_clamped;

    iact_feeder_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (fire),
        .din   (in_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign busy          = (state != ST_IDLE);
    assign iact_enable   = !fifo_empty && busy;
    assign fire          = iact_enable && iact_ready;
    assign push          = in_valid && in_ready;
    assign iact_data     = iact_enable ? fifo_dout : '0;
    assign iact_data_set = set_cnt[SET_WIDTH-1:0];
    assign total         = PUSH_W'(sets_q) * PUSH_W'(words_q);
    assign cfg_zero      = (cfg_sets == '0) || (cfg_words == '0);
    assign sets_clamped  = (cfg_sets > (SET_WIDTH+1)'(SETS)) ? (SET_WIDTH+1)'(SETS) : cfg_sets;
    assign last_fire     = fire && (word_cnt == words_q - LEN_WIDTH'(1))
                                && (set_cnt == sets_q - (SET_WIDTH+1)'(1));
    assign done          = zero_done || (last_fire && state == ST_DRAIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            sets_q    <= '0;
            words_q   <= '0;
            word_cnt  <= '0;
            set_cnt   <= '0;
            push_cnt  <= '0;
            zero_done <= 1'b0;
        end else begin
            state     <= state_next;
            zero_done <= 1'b0;
            if (state == ST_IDLE && start) begin
                sets_q    <= sets_clamped;
                words_q   <= cfg_words;
                word_cnt  <= '0;
                set_cnt   <= '0;
                push_cnt  <= '0;
                zero_done <= cfg_zero;
            end else begin
                if (push) push_cnt <= push_cnt + PUSH_W'(1);
                if (fire) begin
                    if (word_cnt == words_q - LEN_WIDTH'(1)) begin
                        word_cnt <= '0;
                        set_cnt  <= set_cnt + (SET_WIDTH+1)'(1);
                    end else begin
                        word_cnt <= word_cnt + LEN_WIDTH'(1);
                    end
                end
            end
        end
    end

    // in_ready derives only from state and FIFO fullness, never from iact_ready.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !cfg_zero) state_next = ST_RUN;
            end
            ST_RUN: begin
                in_ready = !fifo_full;
                if (push && push_cnt == total - PUSH_W'(1)) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (last_fire) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_iact_router_feeder.sv
// Self-checking bench for iact_router_feeder against a queue-based pass model.
module tb_iact_router_feeder;

    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic [2:0]    cfg_sets;
    logic [7:0]    cfg_words;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          iact_enable;
    logic [DW-1:0] iact_data;
    logic [1:0]    iact_data_set;
    logic          iact_ready;
    logic          busy;
    logic          done;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: one pass is a count of pushes and transfers plus a word queue.
    bit            m_active;
    bit            m_zero;
    int            m_total;
    int            m_words;
    int            m_pushed;
    int            m_xfer;
    logic [DW-1:0] fifo_q[$];
    bit            e_in_ready;
    bit            e_enable;

    iact_router_feeder #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .SETS       (4),
        .SET_WIDTH  (2),
        .LEN_WIDTH  (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_sets      (cfg_sets),
        .cfg_words     (cfg_words),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .iact_enable   (iact_enable),
        .iact_data     (iact_data),
        .iact_data_set (iact_data_set),
        .iact_ready    (iact_ready),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input bit rd);
        logic [DW-1:0] e_data;
        bit            e_done;
        e_in_ready = m_active && (m_pushed < m_total) && (fifo_q.size() < DEPTH);
        e_enable   = m_active && (fifo_q.size() > 0);
        e_data     = e_enable ? fifo_q[0] : '0;
        e_done     = m_zero || (e_enable && rd && (m_xfer == m_total - 1));
        checkValue("busy", 32'(busy), 32'(m_active));
        checkValue("in_ready", 32'(in_ready), 32'(e_in_ready));
        checkValue("iact_enable", 32'(iact_enable), 32'(e_enable));
        checkValue("iact_data", 32'(iact_data), 32'(e_data));
        checkValue("done", 32'(done), 32'(e_done));
        if (e_enable) checkValue("iact_data_set", 32'(iact_data_set), 32'((m_xfer / m_words) % 4));
    endtask

    // Drive one cycle after the falling edge, check, then advance the model.
    task automatic applyStimulus(input bit r, input bit st, input int sets, input int words,
                                 input bit iv, input bit rd);
        rst        = r;
        start      = st;
        cfg_sets   = 3'(sets);
        cfg_words  = 8'(words);
        in_valid   = iv;
        in_data    = DW'($urandom);
        iact_ready = rd;
        #1;
        checkOutput(rd);
        if (r) begin
            m_active = 0;
            m_zero   = 0;
            fifo_q.delete();
        end else begin
            m_zero = 0;
            if (!m_active) begin
                if (st) begin
                    if (sets == 0 || words == 0) begin
                        m_zero = 1;
                    end else begin
                        m_active = 1;
                        m_total  = sets * words;
                        m_words  = words;
                        m_pushed = 0;
                        m_xfer   = 0;
                    end
                end
            end else begin
                if (e_enable && rd) begin
                    void'(fifo_q.pop_front());
                    m_xfer++;
                end
                if (iv && e_in_ready) begin
                    fifo_q.push_back(in_data);
                    m_pushed++;
                end
                if (m_xfer == m_total) m_active = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int sets;
        int words;
        m_active = 0;
        m_zero   = 0;
        @(negedge clk);

        $display("[TB] reset");
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkValue("reset_set", 32'(iact_data_set), 32'd0);

        $display("[TB] basic 2x3 pass");
        applyStimulus(0, 1, 2, 3, 1, 1);
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 2, 3, 1, 1);

        $display("[TB] backpressure 1x8");
        applyStimulus(0, 1, 1, 8, 1, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 8, 1, 0);
        for (int i = 0; i < 14; i++) applyStimulus(0, 0, 1, 8, 1, 1);

        $display("[TB] upstream bubbles 2x2");
        applyStimulus(0, 1, 2, 2, 0, 1);
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, 2, 2, 1'(i % 2), 1);

        $display("[TB] zero configuration and start during run");
        applyStimulus(0, 1, 1, 0, 1, 1);
        applyStimulus(0, 0, 1, 0, 1, 1);
        applyStimulus(0, 0, 1, 0, 1, 1);
        applyStimulus(0, 1, 0, 5, 1, 1);
        applyStimulus(0, 0, 0, 5, 1, 1);
        applyStimulus(0, 1, 3, 4, 1, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 3, 4, 1, 1'($urandom_range(0, 1)));
        applyStimulus(0, 1, 1, 1, 1, 1);
        for (int i = 0; i < 40; i++) applyStimulus(0, 0, 1, 1, 1, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 20 && m_active; i++) applyStimulus(0, 0, 0, 0, 1, 1);

        $display("[TB] mid-pass reset");
        applyStimulus(0, 1, 2, 3, 1, 1);
        for (int i = 0; i < 20 && m_xfer < 3; i++) applyStimulus(0, 0, 2, 3, 1, 1);
        applyStimulus(1, 0, 0, 0, 1, 1);
        checkValue("post_reset_set", 32'(iact_data_set), 32'd0);
        applyStimulus(0, 1, 1, 2, 1, 1);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 2, 1, 1);

        $display("[TB] full FIFO with simultaneous push and pop");
        applyStimulus(0, 1, 1, 8, 1, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 8, 1, 0);
        for (int i = 0; i < 14; i++) applyStimulus(0, 0, 1, 8, 1, 1);

        $display("[TB] randomized passes");
        for (int p = 0; p < 12; p++) begin
            sets  = $urandom_range(1, 4);
            words = $urandom_range(1, 6);
            applyStimulus(0, 1, sets, words, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int i = 0; i < 300 && m_active; i++)
                applyStimulus(0, 1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 6),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            applyStimulus(0, 0, 0, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
